dff_share_arb: RTL and testbench

- Controller that shares one registered mux-capture stage (select between d0/d1, load into q) between two requesters.
- Arbitrates req0/req1 round-robin with a bounded burst length.
- Drives the capture select internally and registers the winner's data into q with source tag and valid.
- Sits in front of any consumer that previously used a hard-wired sel line.

---
 rtl/dff_share_arb_pkg.sv | 25 ++
 rtl/dff_share_arb_sel.sv | 81 ++++++++
 rtl/dff_share_arb.sv | 124 ++++++++++++
 tb/tb_dff_share_arb.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dff_share_arb_pkg.sv
// Shared encodings for the dff_share_arb capture-stage arbiter.
// Optional statistics counters are enabled with DFF_SHARE_ARB_STATS_EN.
package dff_share_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OWN0 = 2'b01;
  localparam logic [1:0] ST_OWN1 = 2'b10;

  localparam logic SRC_D0 = 1'b0;
  localparam logic SRC_D1 = 1'b1;

  localparam int STATS_W = 16;

  // Ownership state that corresponds to a given source
  function automatic logic [1:0] own_state(input logic src);
    logic [1:0] st;
    if (src == SRC_D1) begin
      st = ST_OWN1;
    end else begin
      st = ST_OWN0;
    end
    return st;
  endfunction

endpackage

// File: rtl/dff_share_arb_sel.sv
// Combinational winner, next-state and burst-count logic for dff_share_arb.
module dff_share_arb_sel
  import dff_share_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic [1:0]       state_s,
  input  logic [CNT_W-1:0] cnt_s,
  input  logic             ptr_s,
  input  logic             req0,
  input  logic             req1,
  output logic             cap_s,
  output logic             win_s,
  output logic [1:0]       nxt_state_s,
  output logic [CNT_W-1:0] nxt_cnt_s
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  logic own_s;
  logic own_req_s;
  logic oth_req_s;

  // Decide who captures this edge and where the FSM goes next
  always_comb begin
    cap_s       = 1'b0;
    win_s       = ptr_s;
    nxt_state_s = state_s;
    nxt_cnt_s   = cnt_s;
    own_s       = (state_s == ST_OWN1);
    own_req_s   = own_s ? req1 : req0;
    oth_req_s   = own_s ? req0 : req1;
    case (state_s)
      ST_IDLE: begin
        if (req0 && req1) begin
          cap_s       = 1'b1;
          win_s       = ~ptr_s;
          nxt_state_s = own_state(~ptr_s);
          nxt_cnt_s   = '0;
        end else if (req0) begin
          cap_s       = 1'b1;
          win_s       = SRC_D0;
          nxt_state_s = ST_OWN0;
          nxt_cnt_s   = '0;
        end else if (req1) begin
          cap_s       = 1'b1;
          win_s       = SRC_D1;
          nxt_state_s = ST_OWN1;
          nxt_cnt_s   = '0;
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_OWN0, ST_OWN1: begin
        // The owner keeps the stage until its burst budget runs out under contention
        if (own_req_s && (!oth_req_s || (cnt_s < CNT_LAST))) begin
          cap_s = 1'b1;
          win_s = own_s;
          if (cnt_s < CNT_LAST) begin
            nxt_cnt_s = cnt_s + CNT_W'(1);
          end else begin
            nxt_cnt_s = cnt_s;
          end
        end else if (oth_req_s) begin
          cap_s       = 1'b1;
          win_s       = ~own_s;
          nxt_state_s = own_state(~own_s);
          nxt_cnt_s   = '0;
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      default: begin
        nxt_state_s = ST_IDLE;
        nxt_cnt_s   = '0;
      end
    endcase
  end

endmodule

// File: rtl/dff_share_arb.sv
// Round-robin, burst-bounded sharing of one registered d0/d1 capture stage.
// Define DFF_SHARE_ARB_STATS_EN to add per-requester grant counters.
module dff_share_arb
  import dff_share_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             req0,
  input  logic [WIDTH-1:0] d0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             q_src,
  output logic             gnt0,
  output logic             gnt1
`ifdef DFF_SHARE_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] cnt_gnt0,
  output logic [STATS_W-1:0] cnt_gnt1
`endif
);

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ptr_r;
  logic [WIDTH-1:0] q_r;
  logic             q_valid_r;
  logic             q_src_r;
  logic             gnt0_r;
  logic             gnt1_r;

  logic             cap_s;
  logic             win_s;
  logic [1:0]       nxt_state_s;
  logic [CNT_W-1:0] nxt_cnt_s;
  logic [WIDTH-1:0] cap_data_s;

  dff_share_arb_sel #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_sel (
    .state_s     (state_r),
    .cnt_s       (cnt_r),
    .ptr_s       (ptr_r),
    .req0        (req0),
    .req1        (req1),
    .cap_s       (cap_s),
    .win_s       (win_s),
    .nxt_state_s (nxt_state_s),
    .nxt_cnt_s   (nxt_cnt_s)
  );

  // Capture mux driven by the internal winner instead of an external sel
  always_comb begin
    case (win_s)
      SRC_D1:  cap_data_s = d1;
      default: cap_data_s = d0;
    endcase
  end

  // Arbiter state and capture registers; pointer starts at 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      ptr_r     <= 1'b1;
      q_r       <= '0;
      q_valid_r <= 1'b0;
      q_src_r   <= SRC_D0;
      gnt0_r    <= 1'b0;
      gnt1_r    <= 1'b0;
    end else if (en) begin
      state_r   <= nxt_state_s;
      cnt_r     <= nxt_cnt_s;
      q_valid_r <= cap_s;
      gnt0_r    <= cap_s && (win_s == SRC_D0);
      gnt1_r    <= cap_s && (win_s == SRC_D1);
      if (cap_s) begin
        q_r     <= cap_data_s;
        q_src_r <= win_s;
        ptr_r   <= win_s;
      end
    end else begin
      q_valid_r <= 1'b0;
      gnt0_r    <= 1'b0;
      gnt1_r    <= 1'b0;
    end
  end

  assign q       = q_r;
  assign q_valid = q_valid_r;
  assign q_src   = q_src_r;
  assign gnt0    = gnt0_r;
  assign gnt1    = gnt1_r;

`ifdef DFF_SHARE_ARB_STATS_EN
  logic [STATS_W-1:0] cnt_gnt0_r;
  logic [STATS_W-1:0] cnt_gnt1_r;

  // Free-running grant counters that wrap at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_gnt0_r <= '0;
      cnt_gnt1_r <= '0;
    end else if (en && cap_s) begin
      if (win_s == SRC_D1) begin
        cnt_gnt1_r <= cnt_gnt1_r + STATS_W'(1);
      end else begin
        cnt_gnt0_r <= cnt_gnt0_r + STATS_W'(1);
      end
    end
  end

  assign cnt_gnt0 = cnt_gnt0_r;
  assign cnt_gnt1 = cnt_gnt1_r;
`endif

endmodule

// File: tb/tb_dff_share_arb.sv
// Table-driven, scoreboard-checked bench for dff_share_arb (default parameters).
module tb_dff_share_arb;

  typedef struct packed {
    logic       en;
    logic       req0;
    logic [7:0] d0;
    logic       req1;
    logic [7:0] d1;
    logic [7:0] q;
    logic       q_valid;
    logic       q_src;
    logic       gnt0;
    logic       gnt1;
  } vec_t;

  typedef struct packed {
    logic [7:0] q;
    logic       v;
    logic       s;
    logic       g0;
    logic       g1;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       req0 = 1'b0;
  logic [7:0] d0 = 8'h00;
  logic       req1 = 1'b0;
  logic [7:0] d1 = 8'h00;
  logic [7:0] q;
  logic       q_valid;
  logic       q_src;
  logic       gnt0;
  logic       gnt1;
`ifdef DFF_SHARE_ARB_STATS_EN
  logic [15:0] cnt_gnt0;
  logic [15:0] cnt_gnt1;
  int          exp_g0 = 0;
  int          exp_g1 = 0;
`endif

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];
  vec_t vecs[$];

  dff_share_arb dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req0    (req0),
    .d0      (d0),
    .req1    (req1),
    .d1      (d1),
    .q       (q),
    .q_valid (q_valid),
    .q_src   (q_src),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
`ifdef DFF_SHARE_ARB_STATS_EN
    ,
    .cnt_gnt0 (cnt_gnt0),
    .cnt_gnt1 (cnt_gnt1)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic e, input logic r0, input logic [7:0] a,
                              input logic r1, input logic [7:0] b, input logic [7:0] eq,
                              input logic ev, input logic es, input logic eg0, input logic eg1);
    vec_t v;
    v = {e, r0, a, r1, b, eq, ev, es, eg0, eg1};
    return v;
  endfunction

  task automatic check_out(input string name, input exp_t e);
    exp_t act;
    act = {q, q_valid, q_src, gnt0, gnt1};
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s: got q=%h v=%b src=%b g0=%b g1=%b, expected q=%h v=%b src=%b g0=%b g1=%b",
               name, act.q, act.v, act.s, act.g0, act.g1, e.q, e.v, e.s, e.g0, e.g1);
    end
  endtask

  task automatic step(input vec_t v, input string name);
    @(negedge clk);
    en   = v.en;
    req0 = v.req0;
    d0   = v.d0;
    req1 = v.req1;
    d1   = v.d1;
    sb_q.push_back({v.q, v.q_valid, v.q_src, v.gnt0, v.gnt1});
`ifdef DFF_SHARE_ARB_STATS_EN
    if (v.gnt0) exp_g0++;
    if (v.gnt1) exp_g1++;
`endif
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty, got q=%h expected an entry", name, q);
    end else begin
      check_out(name, sb_q.pop_front());
    end
  endtask

`ifdef DFF_SHARE_ARB_STATS_EN
  task automatic check_stats(input string name);
    checks++;
    if (cnt_gnt0 !== 16'(exp_g0) || cnt_gnt1 !== 16'(exp_g1)) begin
      failures++;
      $display("FAIL %s: got cnt_gnt0=%0d cnt_gnt1=%0d expected %0d %0d",
               name, cnt_gnt0, cnt_gnt1, exp_g0, exp_g1);
    end
  endtask
`endif

  initial begin
    // Tie from reset: four 8'h11 then four 8'h22, alternating
    for (int i = 0; i < 13; i++) begin
      int ph;
      ph = (i / 4) % 2;
      vecs.push_back(mk(1'b1, 1'b1, 8'h11, 1'b1, 8'h22, (ph == 1) ? 8'h22 : 8'h11,
                        1'b1, ph == 1, ph == 0, ph == 1));
    end
    vecs.push_back(mk(1'b1, 1'b0, 8'h11, 1'b0, 8'h22, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0));
    // Single requester never yields
    for (int k = 1; k <= 6; k++) begin
      vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'(k), 8'(k), 1'b1, 1'b1, 1'b0, 1'b1));
    end
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h06, 8'h06, 1'b0, 1'b1, 1'b0, 1'b0));
    // Drop mid-burst: req0 wins the tie (pointer=1), drops after two captures
    vecs.push_back(mk(1'b1, 1'b1, 8'h33, 1'b1, 8'h44, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 8'h33, 1'b1, 8'h44, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 8'h33, 1'b1, 8'h44, 8'h44, 1'b1, 1'b1, 1'b0, 1'b1));
    for (int k = 0; k < 3; k++) begin
      vecs.push_back(mk(1'b1, 1'b1, 8'h33, 1'b1, 8'h44, 8'h44, 1'b1, 1'b1, 1'b0, 1'b1));
    end
    for (int k = 0; k < 4; k++) begin
      vecs.push_back(mk(1'b1, 1'b1, 8'h33, 1'b1, 8'h44, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0));
    end
    for (int k = 0; k < 3; k++) begin
      vecs.push_back(mk(1'b1, 1'b1, 8'h33, 1'b1, 8'h44, 8'h44, 1'b1, 1'b1, 1'b0, 1'b1));
    end
    // Enable stall in OWN1 at cnt=2: one more d1 capture, then d0
    for (int k = 0; k < 3; k++) begin
      vecs.push_back(mk(1'b0, 1'b1, 8'h33, 1'b1, 8'h55, 8'h44, 1'b0, 1'b1, 1'b0, 1'b0));
    end
    vecs.push_back(mk(1'b1, 1'b1, 8'h33, 1'b1, 8'h55, 8'h55, 1'b1, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 8'h33, 1'b1, 8'h55, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h66, 1'b0, 8'h55, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 8'h66, 1'b0, 8'h55, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h66, 1'b0, 8'h55, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0));

    #1;
    check_out("reset_state", 12'h000);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

`ifdef DFF_SHARE_ARB_STATS_EN
    check_stats("stats_count");
`endif

    // Mid-burst async reset: OWN1 would keep d1, reset priority hands the tie to d0
    step(mk(1'b1, 1'b0, 8'hA5, 1'b1, 8'h77, 8'h77, 1'b1, 1'b1, 1'b0, 1'b1), "own1_start");
    step(mk(1'b1, 1'b1, 8'hA5, 1'b1, 8'h77, 8'h77, 1'b1, 1'b1, 1'b0, 1'b1), "own1_burst");
    #1;
    rst = 1'b0;
    #1;
    check_out("async_reset", 12'h000);
`ifdef DFF_SHARE_ARB_STATS_EN
    exp_g0 = 0;
    exp_g1 = 0;
    check_stats("stats_reset");
`endif
    #1;
    rst = 1'b1;
    step(mk(1'b1, 1'b1, 8'hA5, 1'b1, 8'h77, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0), "post_reset_tie");
    step(mk(1'b1, 1'b1, 8'hA5, 1'b1, 8'h77, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0), "post_reset_burst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
